// File: rtl/pipe_pkg.sv
// Shared types and constants for the MEM/WB stage buffer and its skid buffer.
package pipe_pkg;

  localparam int unsigned CTRL_REGWRITE = 0;
  localparam int unsigned CTRL_MEMTOREG = 1;
  localparam int unsigned CTRL_BRTAKEN  = 2;

  localparam int unsigned DATA_W_DEF = 64;
  localparam int unsigned CTRL_W_DEF = 3;
  localparam int unsigned RD_W_DEF   = 5;

  typedef struct packed {
    logic [CTRL_W_DEF-1:0] ctrl;
    logic [RD_W_DEF-1:0]   rd;
    logic [DATA_W_DEF-1:0] rdata;
    logic [DATA_W_DEF-1:0] alu;
  } mem_wb_entry_t;

  // Encoding equals the number of held entries.
  typedef enum logic [1:0] {
    SB_EMPTY = 2'd0,
    SB_ONE   = 2'd1,
    SB_FULL  = 2'd2
  } sb_state_e;

endpackage

// File: rtl/skid_buf.sv
// Generic 2-entry valid/ready skid buffer with a registered in_ready and synchronous flush.
module skid_buf
  import pipe_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occupancy
);

  sb_state_e        state_q, state_d;
  logic [WIDTH-1:0] h_q, s_q;
  logic             in_ready_q, out_valid_q;
  logic             accept, consume;
  logic             load_h_in, load_h_s, load_s;

  assign accept    = in_valid & in_ready_q;
  assign consume   = out_valid_q & out_ready;
  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = h_q;
  assign occupancy = state_q;

  // State and storage registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= SB_EMPTY;
      h_q         <= '0;
      s_q         <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= (state_d != SB_FULL);
      out_valid_q <= (state_d != SB_EMPTY);
      if (load_h_in) h_q <= in_data;
      else if (load_h_s) h_q <= s_q;
      if (load_s) s_q <= in_data;
    end
  end

  // Next state and load enables; flush overrides everything and drops any accept.
  always_comb begin
    state_d   = state_q;
    load_h_in = 1'b0;
    load_h_s  = 1'b0;
    load_s    = 1'b0;
    if (flush) begin
      state_d = SB_EMPTY;
    end else begin
      case (state_q)
        SB_EMPTY: begin
          if (accept) begin
            state_d   = SB_ONE;
            load_h_in = 1'b1;
          end
        end
        SB_ONE: begin
          if (accept && consume) begin
            load_h_in = 1'b1;
          end else if (accept) begin
            state_d = SB_FULL;
            load_s  = 1'b1;
          end else if (consume) begin
            state_d = SB_EMPTY;
          end
        end
        SB_FULL: begin
          if (consume) begin
            state_d  = SB_ONE;
            load_h_s = 1'b1;
          end
        end
        default: state_d = SB_EMPTY;
      endcase
    end
  end

endmodule

// File: rtl/mem_wb_stage_buf.sv
// MEM/WB pipeline stage with valid/ready skid buffering, flush, and a forwarding copy
// for the hazard unit.
module mem_wb_stage_buf
  import pipe_pkg::*;
#(
  parameter int unsigned DATA_W      = 64,
  parameter int unsigned CTRL_W      = 3,
  parameter int unsigned RD_W        = 5,
  parameter bit          FWD_NEGEDGE = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [RD_W-1:0]   in_rd,
  input  logic [DATA_W-1:0] in_rdata,
  input  logic [DATA_W-1:0] in_alu,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [RD_W-1:0]   out_rd,
  output logic [DATA_W-1:0] out_rdata,
  output logic [DATA_W-1:0] out_alu,
  output logic              fwd_valid,
  output logic [RD_W-1:0]   fwd_rd,
  output logic [DATA_W-1:0] fwd_alu,
  output logic [1:0]        occupancy
);

  localparam int unsigned PAY_W = CTRL_W + RD_W + 2 * DATA_W;

  logic [PAY_W-1:0] in_pay, out_pay;

  assign in_pay = {in_ctrl, in_rd, in_rdata, in_alu};
  assign {out_ctrl, out_rd, out_rdata, out_alu} = out_pay;

  skid_buf #(.WIDTH(PAY_W)) u_skid (
    .clk       (clk),
    .rst_n     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_pay),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_pay),
    .occupancy (occupancy)
  );

  if (FWD_NEGEDGE) begin : g_fwd_neg
    logic              fwd_valid_q;
    logic [RD_W-1:0]   fwd_rd_q;
    logic [DATA_W-1:0] fwd_alu_q;
    logic              accept;

    assign accept = in_valid & in_ready;

    // Half-cycle early copy of the entry being accepted at the coming posedge.
    always_ff @(negedge clk or negedge reset) begin
      if (!reset) begin
        fwd_valid_q <= 1'b0;
        fwd_rd_q    <= '0;
        fwd_alu_q   <= '0;
      end else begin
        fwd_valid_q <= accept & in_ctrl[CTRL_REGWRITE] & ~flush;
        fwd_rd_q    <= in_rd;
        fwd_alu_q   <= in_alu;
      end
    end

    assign fwd_valid = fwd_valid_q;
    assign fwd_rd    = fwd_rd_q;
    assign fwd_alu   = fwd_alu_q;
  end else begin : g_fwd_head
    assign fwd_valid = out_valid & out_ctrl[CTRL_REGWRITE];
    assign fwd_rd    = out_rd;
    assign fwd_alu   = out_alu;
  end

endmodule

// File: tb/tb_mem_wb_stage_buf.sv
// Directed self-checking bench for mem_wb_stage_buf (default parameters, negedge forwarding).
module tb_mem_wb_stage_buf;

  logic        clk;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_ctrl;
  logic [4:0]  in_rd;
  logic [63:0] in_rdata;
  logic [63:0] in_alu;
  logic        out_valid;
  logic        out_ready;
  logic [2:0]  out_ctrl;
  logic [4:0]  out_rd;
  logic [63:0] out_rdata;
  logic [63:0] out_alu;
  logic        fwd_valid;
  logic [4:0]  fwd_rd;
  logic [63:0] fwd_alu;
  logic [1:0]  occupancy;

  int total = 0;
  int bad   = 0;

  mem_wb_stage_buf dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_ctrl   (in_ctrl),
    .in_rd     (in_rd),
    .in_rdata  (in_rdata),
    .in_alu    (in_alu),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_ctrl  (out_ctrl),
    .out_rd    (out_rd),
    .out_rdata (out_rdata),
    .out_alu   (out_alu),
    .fwd_valid (fwd_valid),
    .fwd_rd    (fwd_rd),
    .fwd_alu   (fwd_alu),
    .occupancy (occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [2:0] c, input logic [4:0] rd, input logic [63:0] alu);
    in_valid = v;
    in_ctrl  = c;
    in_rd    = rd;
    in_alu   = alu;
    in_rdata = alu ^ 64'hFFFF_0000_0000_0000;
  endtask

  initial begin
    reset = 1'b0;
    flush = 1'b0;
    out_ready = 1'b0;
    drive(1'b1, 3'b001, 5'd2, 64'h22);

    // Reset held with traffic present
    repeat (3) tick();
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready",  64'(in_ready),  64'd1);
    chk("rst_occ",       64'(occupancy), 64'd0);
    chk("rst_fwd_valid", 64'(fwd_valid), 64'd0);
    chk("rst_fwd_rd",    64'(fwd_rd),    64'd0);
    chk("rst_fwd_alu",   fwd_alu,        64'd0);
    chk("rst_out_rd",    64'(out_rd),    64'd0);

    // First entry one cycle after accept
    reset = 1'b1;
    tick();
    chk("first_valid", 64'(out_valid), 64'd1);
    chk("first_rd",    64'(out_rd),    64'd2);
    chk("first_rdata", out_rdata,      64'hFFFF_0000_0000_0022);
    chk("first_occ",   64'(occupancy), 64'd1);
    drive(1'b0, 3'b000, 5'd0, 64'h0);
    out_ready = 1'b1;
    tick();
    chk("drain_occ", 64'(occupancy), 64'd0);

    // Back-to-back streaming
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, 3'b001, 5'(i), 64'(i * 16));
      tick();
      chk("stream_valid", 64'(out_valid), 64'd1);
      chk("stream_rd",    64'(out_rd),    64'(i));
      chk("stream_alu",   out_alu,        64'(i * 16));
      chk("stream_ready", 64'(in_ready),  64'd1);
    end
    drive(1'b0, 3'b000, 5'd0, 64'h0);
    tick();
    chk("stream_end_occ", 64'(occupancy), 64'd0);

    // Back-pressure fills the skid entry
    out_ready = 1'b0;
    drive(1'b1, 3'b001, 5'd3, 64'h3);
    tick();
    chk("bp_occ1",   64'(occupancy), 64'd1);
    chk("bp_ready1", 64'(in_ready),  64'd1);
    drive(1'b1, 3'b001, 5'd4, 64'h4);
    tick();
    chk("bp_occ2",   64'(occupancy), 64'd2);
    chk("bp_ready2", 64'(in_ready),  64'd0);
    drive(1'b1, 3'b001, 5'd5, 64'h5);
    tick();
    chk("bp_hold_occ", 64'(occupancy), 64'd2);
    chk("bp_hold_rd",  64'(out_rd),    64'd3);
    chk("bp_hold_rdy", 64'(in_ready),  64'd0);
    out_ready = 1'b1;
    tick();
    chk("bp_out4",   64'(out_rd),    64'd4);
    chk("bp_occ_a",  64'(occupancy), 64'd1);
    chk("bp_rdy_a",  64'(in_ready),  64'd1);
    tick();
    chk("bp_out5",   64'(out_rd),    64'd5);
    chk("bp_occ_b",  64'(occupancy), 64'd1);
    drive(1'b0, 3'b000, 5'd0, 64'h0);
    tick();
    chk("bp_empty",  64'(occupancy), 64'd0);

    // Flush while full
    out_ready = 1'b0;
    drive(1'b1, 3'b001, 5'd10, 64'hA);
    tick();
    drive(1'b1, 3'b001, 5'd11, 64'hB);
    tick();
    chk("fl_pre_occ", 64'(occupancy), 64'd2);
    flush = 1'b1;
    drive(1'b1, 3'b001, 5'd9, 64'h9);
    tick();
    chk("fl_occ",   64'(occupancy), 64'd0);
    chk("fl_valid", 64'(out_valid), 64'd0);
    chk("fl_ready", 64'(in_ready),  64'd1);

    // Flush in ONE drops a same-cycle accept and suppresses forwarding
    flush = 1'b0;
    drive(1'b1, 3'b001, 5'd12, 64'hC);
    tick();
    chk("fl1_occ", 64'(occupancy), 64'd1);
    flush = 1'b1;
    out_ready = 1'b1;
    drive(1'b1, 3'b001, 5'd9, 64'h9);
    @(negedge clk);
    #1;
    chk("fl1_fwd_valid", 64'(fwd_valid), 64'd0);
    tick();
    chk("fl1_occ_after", 64'(occupancy), 64'd0);
    chk("fl1_valid",     64'(out_valid), 64'd0);
    flush = 1'b0;
    drive(1'b0, 3'b000, 5'd0, 64'h0);
    tick();
    chk("fl_no_ghost", 64'(out_valid), 64'd0);

    // Negedge forwarding ahead of the posedge capture
    drive(1'b1, 3'b001, 5'd7, 64'hDEAD);
    @(negedge clk);
    #1;
    chk("fwd_valid1", 64'(fwd_valid), 64'd1);
    chk("fwd_rd1",    64'(fwd_rd),    64'd7);
    chk("fwd_alu1",   fwd_alu,        64'hDEAD);
    chk("fwd_early",  64'(out_valid), 64'd0);
    tick();
    chk("fwd_out_rd", 64'(out_rd), 64'd7);
    drive(1'b1, 3'b110, 5'd8, 64'hBEEF);
    @(negedge clk);
    #1;
    chk("fwd_nowr_valid", 64'(fwd_valid), 64'd0);
    chk("fwd_nowr_rd",    64'(fwd_rd),    64'd8);
    tick();
    chk("fwd_out_ctrl", 64'(out_ctrl), 64'd6);
    drive(1'b0, 3'b001, 5'd13, 64'h13);
    @(negedge clk);
    #1;
    chk("fwd_noacc_valid", 64'(fwd_valid), 64'd0);
    tick();

    // Asynchronous reset while full
    out_ready = 1'b0;
    drive(1'b1, 3'b001, 5'd14, 64'hE);
    tick();
    drive(1'b1, 3'b001, 5'd15, 64'hF);
    tick();
    chk("mr_pre_occ", 64'(occupancy), 64'd2);
    drive(1'b0, 3'b000, 5'd0, 64'h0);
    #1;
    reset = 1'b0;
    #1;
    chk("mr_occ",   64'(occupancy), 64'd0);
    chk("mr_valid", 64'(out_valid), 64'd0);
    chk("mr_ready", 64'(in_ready),  64'd1);
    reset = 1'b1;
    out_ready = 1'b1;
    tick();
    chk("mr_stale1", 64'(out_valid), 64'd0);
    tick();
    chk("mr_stale2", 64'(out_valid), 64'd0);
    drive(1'b1, 3'b001, 5'd21, 64'h21);
    tick();
    chk("mr_recover_rd",  64'(out_rd),   64'd21);
    chk("mr_recover_alu", out_alu,       64'h21);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_wb_stage_buf.md
Name: mem_wb_stage_buf

Overview:
- Parametrised successor to the MEM/WB pipeline register.
- Sits between the memory stage and write-back, carrying control bits, destination register and two data words (load data, ALU result).
- Adds a valid/ready handshake with a 2-entry skid buffer for back-pressure, a synchronous flush that inserts bubbles, and an optional negative-edge forwarding copy for the hazard unit.

Parameters:
- DATA_W, 64, width of each data word (load data, ALU result).
- CTRL_W, 3, width of the packed control field (bit0 RegWrite, bit1 MemtoReg, bit2 BrTaken; upper bits pass through).
- RD_W, 5, destination register index width.
- FWD_NEGEDGE, 1: 1 = forwarding outputs are a negedge capture of accepted input; 0 = forwarding outputs mirror the head entry combinationally.

Ports:
- clk  in  1  single clock; all state is on posedge except the forwarding copy.
- reset  in  1  asynchronous, active-low (0 = reset asserted).
- flush  in  1  synchronous kill of all held entries.
- in_valid  in  1  upstream entry valid.
- in_ready  out  1  stage can accept an entry this cycle.
- in_ctrl  in  CTRL_W  control field.
- in_rd  in  RD_W  destination register.
- in_rdata  in  DATA_W  memory read data.
- in_alu  in  DATA_W  ALU result.
- out_valid  out  1  head entry valid.
- out_ready  in  1  downstream consumes the head this cycle.
- out_ctrl  out  CTRL_W  head control field.
- out_rd  out  RD_W  head destination register.
- out_rdata  out  DATA_W  head memory read data.
- out_alu  out  DATA_W  head ALU result.
- fwd_valid  out  1  forwarding copy valid (RegWrite qualified).
- fwd_rd  out  RD_W  forwarding destination register.
- fwd_alu  out  DATA_W  forwarding ALU result.
- occupancy  out  2  entries held (0..2).

Behaviour:
- Storage: head register H and skid register S, each with a valid bit.
- State encoding by occupancy: EMPTY (0), ONE (H valid), FULL (H and S valid).
- Reset (reset=0, asynchronous):
  - all valid bits cleared; every payload output and every fwd_* output is 0.
  - in_ready=1, out_valid=0, occupancy=0.
  - Reset mid-transfer discards everything.
- in_ready is registered: in_ready = !S.valid. Ready never depends combinationally on out_ready.
- Transfers: accept = in_valid & in_ready; consume = out_valid & out_ready.
- Latency: an accepted entry appears on out_* on the next posedge (1 cycle) when H is empty or consumed the same cycle.
- Transitions on posedge (flush=0):
  - EMPTY + accept -> ONE (H <= in).
  - ONE + accept + consume -> ONE (H <= in).
  - ONE + accept, no consume -> FULL (S <= in).
  - ONE + consume only -> EMPTY.
  - FULL + consume -> ONE (H <= S); in_ready was 0, so no accept is possible.
  - FULL, no consume -> hold.
- Ordering is strictly FIFO; no entry is duplicated or dropped without flush.
- flush=1 at posedge:
  - H.valid and S.valid cleared; any same-cycle accept is dropped; the consume still counts for the downstream side.
  - Next cycle: occupancy=0, in_ready=1.
  - Payload registers need not clear; out_* payload is don't-care while out_valid=0.
- flush and reset together: reset dominates.
- out_ctrl[0] (RegWrite) is presented raw. Write-back qualifies the register-file write with out_valid & out_ctrl[0].
- FWD_NEGEDGE=1:
  - On each negedge, fwd_* <= {accept & in_ctrl[0], in_rd, in_alu}, evaluated with that half-cycle's input values.
  - This gives the hazard unit the MEM value half a cycle before the posedge capture.
  - A flush that is high at the negedge forces fwd_valid <= 0.
- FWD_NEGEDGE=0: fwd_valid = out_valid & out_ctrl[0]; fwd_rd = out_rd; fwd_alu = out_alu.
- occupancy = H.valid + S.valid (S.valid implies H.valid).
- No arithmetic on payload; all widths pass through unchanged.

Decomposition:
- Package pipe_pkg:
  - constants CTRL_REGWRITE=0, CTRL_MEMTOREG=1, CTRL_BRTAKEN=2.
  - typedef mem_wb_entry_t as a packed struct {ctrl, rd, rdata, alu}, sized from the parameters' defaults.
- One sub-module, skid_buf: a generic 2-entry valid/ready skid buffer over a WIDTH-bit payload.
  - mem_wb_stage_buf instantiates skid_buf and adds flush fan-out and the forwarding capture logic.

Test Plan:
- Reset: hold reset=0 for 3 cycles with in_valid=1 -> out_valid=0, in_ready=1, occupancy=0, all fwd_* = 0; release -> the first entry appears 1 cycle after accept.
- Streaming: out_ready=1, entries rd=1..8 with alu=0x10..0x80 on back-to-back cycles -> out sequence rd=1..8 in order, one per cycle, in_ready constantly 1.
- Back-pressure:
  - out_ready=0, send rd=3 then rd=4 -> occupancy=2, in_ready=0, rd=5 held upstream.
  - Raise out_ready -> outputs rd=3, rd=4, rd=5 in order, nothing lost.
- Flush while FULL: occupancy=2, flush=1 with in_valid=1 (rd=9) -> next cycle occupancy=0, out_valid=0, in_ready=1; rd=9 never emerges.
- Forwarding (FWD_NEGEDGE=1): accept rd=7, alu=0xDEAD, RegWrite=1 -> fwd_rd=7, fwd_alu=0xDEAD, fwd_valid=1 after the negedge, before the posedge; RegWrite=0 -> fwd_valid=0.
- Mid-operation reset: occupancy=2, then reset=0 asynchronously between edges -> out_valid and occupancy drop to 0 immediately; no stale entry appears after release.
